// File: rtl/pc_pkg.sv
// Shared types and constants for the RV32I fetch program counter.
// Optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_pkg;

  // Index into the flag vector {EQ,NE,0,0,LT,GE,LTU,GEU}
  typedef enum logic [2:0] {
    BGEU = 3'd0,
    BLTU = 3'd1,
    BGE  = 3'd2,
    BLT  = 3'd3,
    BNE  = 3'd6,
    BEQ  = 3'd7
  } branch_code_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam int INC_NORMAL = 4;
  localparam int INC_COMP   = 2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Built only when PC_RAS_EN is defined.
module pc_ras #(
  parameter int dataW     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [dataW-1:0] push_data,
  output logic [dataW-1:0] top,
  output logic             empty
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [dataW-1:0] mem_q [RAS_DEPTH];
  logic [dataW-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign ptr_inc = ptr_q + PW'(1);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && pop && (cnt_q != '0)) begin
      // Call-through-return: replace the top in place
      mem_d[ptr_q] = push_data;
    end else if (push) begin
      ptr_d        = ptr_inc;
      mem_d[ptr_inc] = push_data;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32I fetch program counter with valid/ready handshake, trap and misalign redirect.
// Define PC_RAS_EN to add the return-address stack (pc_ras).
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int               dataW      = 32,
  parameter logic [dataW-1:0] RESET_VEC  = 32'h0000_0000,
  parameter logic [dataW-1:0] TRAP_VEC   = 32'h0000_0100,
  parameter bit               COMPRESSED = 1'b0,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EQ,
  input  logic             NE,
  input  logic             LT,
  input  logic             LTU,
  input  logic             GE,
  input  logic             GEU,
  input  logic             TestBranch,
  input  logic             AlwaysBranch,
  input  logic             AbsoluteBranch,
  input  logic [2:0]       BranchType,
  input  logic [dataW-1:0] BranchAddr,
  input  logic             InsCompressed,
  input  logic             IsCall,
  input  logic             IsReturn,
  input  logic             Trap,
  input  logic             FetchReady,
  output logic             FetchValid,
  output logic [dataW-1:0] ProgAddr,
  output logic             MisalignTrap,
  output logic [dataW-1:0] MisalignAddr,
  output logic             RasEmpty
);

  pc_state_e        state_q, state_d;
  logic [dataW-1:0] pc_q, pc_d;
  logic [dataW-1:0] mis_addr_q, mis_addr_d;
  logic             mis_trap_q, mis_trap_d;
  logic             trap_pend_q, trap_pend_d;

  logic [7:0]       flags;
  logic             taken, fire, misaligned, br_commit;
  logic [dataW-1:0] incr, seq_pc, br_off, tgt_br, tgt;
  logic [dataW-1:0] ras_top;
  logic             ras_empty, use_ret;

  assign flags  = {EQ, NE, 1'b0, 1'b0, LT, GE, LTU, GEU};
  assign taken  = (TestBranch & flags[BranchType]) | AlwaysBranch;
  assign incr   = (COMPRESSED && InsCompressed) ? dataW'(INC_COMP) : dataW'(INC_NORMAL);
  assign seq_pc = pc_q + incr;
  assign br_off = BranchAddr & ~dataW'(1);
  assign tgt_br = AbsoluteBranch ? br_off : (pc_q + br_off);

`ifdef PC_RAS_EN
  logic ras_push, ras_pop;

  assign use_ret  = IsReturn & ~ras_empty;
  assign ras_push = br_commit & IsCall;
  assign ras_pop  = br_commit & use_ret;

  pc_ras #(
    .dataW    (dataW),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(seq_pc),
    .top      (ras_top),
    .empty    (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;

  assign use_ret    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_ras = IsCall ^ IsReturn ^ br_commit;
`endif

  assign tgt        = use_ret ? ras_top : tgt_br;
  assign misaligned = !COMPRESSED && tgt[1];
  assign fire       = (state_q == RUN) && FetchReady;
  // Only a clean taken branch may touch the RAS; trap and misalign redirects never do
  assign br_commit  = fire && !(Trap || trap_pend_q) && taken && !misaligned;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mis_addr_d  = mis_addr_q;
    mis_trap_d  = 1'b0;
    trap_pend_d = trap_pend_q;
    unique case (state_q)
      BOOT, FAULT: begin
        state_d = RUN;
        if (Trap) trap_pend_d = 1'b1;
      end
      RUN: begin
        if (fire) begin
          trap_pend_d = 1'b0;
          if (Trap || trap_pend_q) begin
            pc_d = TRAP_VEC;
          end else if (taken) begin
            if (misaligned) begin
              pc_d       = TRAP_VEC;
              mis_addr_d = tgt;
              mis_trap_d = 1'b1;
              state_d    = FAULT;
            end else begin
              pc_d = tgt;
            end
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      mis_addr_q  <= '0;
      mis_trap_q  <= 1'b0;
      trap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mis_addr_q  <= mis_addr_d;
      mis_trap_q  <= mis_trap_d;
      trap_pend_q <= trap_pend_d;
    end
  end

  assign FetchValid   = (state_q == RUN);
  assign ProgAddr     = pc_q;
  assign MisalignTrap = mis_trap_q;
  assign MisalignAddr = mis_addr_q;
  assign RasEmpty     = ras_empty;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default parameters, COMPRESSED=0).
// RAS scenario runs when PC_RAS_EN is defined; otherwise the RAS-less fallback is checked.
module tb_pc_fetch_unit;

  logic        clock, reset;
  logic        EQ, NE, LT, LTU, GE, GEU;
  logic        TestBranch, AlwaysBranch, AbsoluteBranch;
  logic [2:0]  BranchType;
  logic [31:0] BranchAddr;
  logic        InsCompressed, IsCall, IsReturn, Trap, FetchReady;
  logic        FetchValid, MisalignTrap, RasEmpty;
  logic [31:0] ProgAddr, MisalignAddr;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .EQ            (EQ),
    .NE            (NE),
    .LT            (LT),
    .LTU           (LTU),
    .GE            (GE),
    .GEU           (GEU),
    .TestBranch    (TestBranch),
    .AlwaysBranch  (AlwaysBranch),
    .AbsoluteBranch(AbsoluteBranch),
    .BranchType    (BranchType),
    .BranchAddr    (BranchAddr),
    .InsCompressed (InsCompressed),
    .IsCall        (IsCall),
    .IsReturn      (IsReturn),
    .Trap          (Trap),
    .FetchReady    (FetchReady),
    .FetchValid    (FetchValid),
    .ProgAddr      (ProgAddr),
    .MisalignTrap  (MisalignTrap),
    .MisalignAddr  (MisalignAddr),
    .RasEmpty      (RasEmpty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    EQ = 0; NE = 0; LT = 0; LTU = 0; GE = 0; GEU = 0;
    TestBranch = 0; AlwaysBranch = 0; AbsoluteBranch = 0;
    BranchType = 3'd0; BranchAddr = 32'h0;
    InsCompressed = 0; IsCall = 0; IsReturn = 0; Trap = 0; FetchReady = 1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic jump_abs(input logic [31:0] a);
    AlwaysBranch = 1; AbsoluteBranch = 1; BranchAddr = a;
    step();
    chk("jump_abs", ProgAddr, a);
    clear_ctl();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clock = 0;
    reset = 0;
    clear_ctl();

    // Reset values
    #2;
    chk("rst_pc", ProgAddr, 32'h0);
    chk("rst_fv", {31'b0, FetchValid}, 32'h0);
    chk("rst_mt", {31'b0, MisalignTrap}, 32'h0);
    chk("rst_ma", MisalignAddr, 32'h0);
    chk("rst_re", {31'b0, RasEmpty}, 32'h1);

    // Boot then three sequential fires
    #10 reset = 1;
    #1;
    chk("boot_fv", {31'b0, FetchValid}, 32'h0);
    step();
    chk("run_fv", {31'b0, FetchValid}, 32'h1);
    chk("run_pc", ProgAddr, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", ProgAddr, 32'(4 * i));
    end

    // Stall: no fire holds everything
    jump_abs(32'h20);
    FetchReady = 0; AlwaysBranch = 1; BranchAddr = 32'h10;
    repeat (5) begin
      step();
      chk("stall_pc", ProgAddr, 32'h20);
    end
    FetchReady = 1;
    step();
    chk("stall_rel", ProgAddr, 32'h30);
    clear_ctl();

    // Conditional branches
    jump_abs(32'h40);
    TestBranch = 1; BranchType = 3'd7; EQ = 1; BranchAddr = 32'hFFFF_FFF8;
    step();
    chk("beq_back", ProgAddr, 32'h38);
    clear_ctl();
    jump_abs(32'h40);
    TestBranch = 1; BranchType = 3'd7; EQ = 0; BranchAddr = 32'hFFFF_FFF8;
    step();
    chk("beq_nt", ProgAddr, 32'h44);
    clear_ctl();
    jump_abs(32'h40);
    TestBranch = 1; BranchType = 3'd7; EQ = 1; BranchAddr = 32'h11;
    step();
    chk("beq_bit0", ProgAddr, 32'h50);
    clear_ctl();
    TestBranch = 1; BranchType = 3'd6; NE = 1; BranchAddr = 32'h8;
    step();
    chk("bne_t", ProgAddr, 32'h58);
    clear_ctl();
    TestBranch = 1; BranchType = 3'd1; LT = 1; GEU = 1; BranchAddr = 32'h8;
    step();
    chk("bltu_nt", ProgAddr, 32'h5C);
    clear_ctl();
    TestBranch = 1; BranchType = 3'd2; GE = 1; BranchAddr = 32'h24;
    step();
    chk("bge_t", ProgAddr, 32'h80);
    clear_ctl();

    // Misaligned jump target
    jump_abs(32'h100);
    AlwaysBranch = 1; BranchAddr = 32'h6;
    step();
    chk("mis_pc", ProgAddr, 32'h100);
    chk("mis_addr", MisalignAddr, 32'h106);
    chk("mis_pulse", {31'b0, MisalignTrap}, 32'h1);
    chk("mis_fv", {31'b0, FetchValid}, 32'h0);
    clear_ctl();
    step();
    chk("fault_fv", {31'b0, FetchValid}, 32'h1);
    chk("fault_pulse", {31'b0, MisalignTrap}, 32'h0);
    chk("fault_pc", ProgAddr, 32'h100);
    step();
    chk("fault_seq", ProgAddr, 32'h104);

    // Trap raised during FAULT is applied at the first RUN fire
    AlwaysBranch = 1; BranchAddr = 32'h12;
    step();
    chk("mis2_addr", MisalignAddr, 32'h116);
    chk("mis2_pc", ProgAddr, 32'h100);
    clear_ctl();
    Trap = 1;
    step();
    chk("ltrap_hold", ProgAddr, 32'h100);
    Trap = 0;
    step();
    chk("ltrap_apply", ProgAddr, 32'h100);
    step();
    chk("ltrap_seq", ProgAddr, 32'h104);

    // Trap without fire in RUN is dropped
    FetchReady = 0; Trap = 1;
    step();
    chk("trap_nofire", ProgAddr, 32'h104);
    Trap = 0; FetchReady = 1;
    step();
    chk("trap_dropped", ProgAddr, 32'h108);

    // Trap beats a jump; address wrap
    jump_abs(32'h80);
    Trap = 1; AlwaysBranch = 1; BranchAddr = 32'h40;
    step();
    chk("trap_prio", ProgAddr, 32'h100);
    clear_ctl();
    jump_abs(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", ProgAddr, 32'h0);
    chk("wrap_mt", {31'b0, MisalignTrap}, 32'h0);

`ifdef PC_RAS_EN
    chk("ras_empty0", {31'b0, RasEmpty}, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      jump_abs(32'(k * 16));
      AlwaysBranch = 1; AbsoluteBranch = 1; IsCall = 1; BranchAddr = 32'h200;
      step();
      chk("call_pc", ProgAddr, 32'h200);
      clear_ctl();
    end
    chk("ras_full", {31'b0, RasEmpty}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      AlwaysBranch = 1; AbsoluteBranch = 1; IsReturn = 1; BranchAddr = 32'h300;
      step();
      chk("ret_pc", ProgAddr, 32'h54 - 32'(k * 16));
      clear_ctl();
    end
    chk("ras_drained", {31'b0, RasEmpty}, 32'h1);
    AlwaysBranch = 1; AbsoluteBranch = 1; IsReturn = 1; BranchAddr = 32'h300;
    step();
    chk("ret_fallback", ProgAddr, 32'h300);
    clear_ctl();
`else
    jump_abs(32'h10);
    AlwaysBranch = 1; AbsoluteBranch = 1; IsCall = 1; BranchAddr = 32'h200;
    step();
    chk("call_pc", ProgAddr, 32'h200);
    chk("noras_empty", {31'b0, RasEmpty}, 32'h1);
    clear_ctl();
    AlwaysBranch = 1; AbsoluteBranch = 1; IsReturn = 1; BranchAddr = 32'h300;
    step();
    chk("ret_fallback", ProgAddr, 32'h300);
    clear_ctl();
`endif

    // Asynchronous reset in the middle of a FAULT
    AlwaysBranch = 1; BranchAddr = 32'h2;
    step();
    chk("mis3_addr", MisalignAddr, 32'h302);
    clear_ctl();
    #1 reset = 0;
    #1;
    chk("arst_pc", ProgAddr, 32'h0);
    chk("arst_ma", MisalignAddr, 32'h0);
    chk("arst_mt", {31'b0, MisalignTrap}, 32'h0);
    chk("arst_fv", {31'b0, FetchValid}, 32'h0);
    chk("arst_re", {31'b0, RasEmpty}, 32'h1);
    #1 reset = 1;
    step();
    chk("rerun_fv", {31'b0, FetchValid}, 32'h1);
    step();
    chk("rerun_pc", ProgAddr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
